// File: rtl/fb_write_arbiter.sv
// Write-side controller for the overlay frame buffer: round-robin arbitration of two pixel
// requesters onto one registered write port, plus a full-screen clear sweep.
module fb_write_arbiter #(
  parameter int unsigned VGA_WIDTH  = 640,
  parameter int unsigned VGA_HEIGHT = 480,
  parameter int unsigned ADDR_W     = 19
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR_REQ,
  input  logic              REQ0_VALID,
  input  logic [9:0]        REQ0_X,
  input  logic [9:0]        REQ0_Y,
  input  logic [23:0]       REQ0_DATA,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic [9:0]        REQ1_X,
  input  logic [9:0]        REQ1_Y,
  input  logic [23:0]       REQ1_DATA,
  output logic              REQ1_READY,
  output logic              WRITE_EN,
  output logic [ADDR_W-1:0] WRITE_ADDR,
  output logic [23:0]       WRITE_DATA,
  output logic              BUSY,
  output logic              CLEAR_DONE,
  output logic              DROP
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(VGA_WIDTH * VGA_HEIGHT - 1);
  localparam logic [10:0]       XLim     = 11'(VGA_WIDTH);
  localparam logic [10:0]       YLim     = 11'(VGA_HEIGHT);

  typedef enum logic [0:0] {StServe, StClear} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                last_q, last_d;  // 1: REQ1 was served last
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [23:0]         data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;

  logic                gnt0, gnt1, accept, in_range;
  logic [9:0]          sel_x, sel_y;
  logic [23:0]         sel_data;
  logic [ADDR_W-1:0]   pix_addr, cnt_nxt;

  // On a tie the requester not served last wins.
  assign gnt1     = REQ1_VALID & (~REQ0_VALID | ~last_q);
  assign gnt0     = REQ0_VALID & ~gnt1;
  assign sel_x    = gnt1 ? REQ1_X : REQ0_X;
  assign sel_y    = gnt1 ? REQ1_Y : REQ0_Y;
  assign sel_data = gnt1 ? REQ1_DATA : REQ0_DATA;
  assign in_range = ({1'b0, sel_x} < XLim) && ({1'b0, sel_y} < YLim);
  assign pix_addr = ADDR_W'(sel_y) * ADDR_W'(VGA_WIDTH) + ADDR_W'(sel_x);
  assign cnt_nxt  = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    accept     = 1'b0;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    unique case (state_q)
      StServe: begin
        if (CLEAR_REQ) begin
          state_d = StClear;
          cnt_d   = '0;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = '0;
          busy_d  = 1'b1;
          done_d  = (LastAddr == '0);
        end else begin
          REQ0_READY = ~RESET & gnt0;
          REQ1_READY = ~RESET & gnt1;
          accept     = gnt0 | gnt1;
          if (accept) begin
            last_d = gnt1;
            if (in_range) begin
              we_d   = 1'b1;
              addr_d = pix_addr;
              data_d = sel_data;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
      end
      StClear: begin
        // cnt_q is the address currently on the write bus.
        if (cnt_q == LastAddr) begin
          state_d = StServe;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_nxt;
          we_d   = 1'b1;
          addr_d = cnt_nxt;
          data_d = '0;
          busy_d = 1'b1;
          done_d = (cnt_nxt == LastAddr);
        end
      end
      default: state_d = StServe;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StServe;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign WRITE_EN   = we_q;
  assign WRITE_ADDR = addr_q;
  assign WRITE_DATA = data_q;
  assign BUSY       = busy_q;
  assign CLEAR_DONE = done_q;
  assign DROP       = drop_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench: full-size instance for pixel paths and reset mid-sweep, and a
// 16x12 instance so a complete clear sweep fits in a short run.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_m, clr_s;
  logic        v0, v1;
  logic [9:0]  x0, y0, x1, y1;
  logic [23:0] d0, d1;

  logic        m_r0, m_r1, m_we, m_busy, m_done, m_drop;
  logic [18:0] m_addr;
  logic [23:0] m_data;
  logic        s_r0, s_r1, s_we, s_busy, s_done, s_drop;
  logic [7:0]  s_addr;
  logic [23:0] s_data;

  int checks = 0;
  int failures = 0;
  int sweep_errs;

  always #5 clk = ~clk;

  fb_write_arbiter u_dut (
    .CLK(clk), .RESET(rst), .CLEAR_REQ(clr_m),
    .REQ0_VALID(v0), .REQ0_X(x0), .REQ0_Y(y0), .REQ0_DATA(d0), .REQ0_READY(m_r0),
    .REQ1_VALID(v1), .REQ1_X(x1), .REQ1_Y(y1), .REQ1_DATA(d1), .REQ1_READY(m_r1),
    .WRITE_EN(m_we), .WRITE_ADDR(m_addr), .WRITE_DATA(m_data),
    .BUSY(m_busy), .CLEAR_DONE(m_done), .DROP(m_drop)
  );

  fb_write_arbiter #(.VGA_WIDTH(16), .VGA_HEIGHT(12), .ADDR_W(8)) u_small (
    .CLK(clk), .RESET(rst), .CLEAR_REQ(clr_s),
    .REQ0_VALID(v0), .REQ0_X(x0), .REQ0_Y(y0), .REQ0_DATA(d0), .REQ0_READY(s_r0),
    .REQ1_VALID(v1), .REQ1_X(x1), .REQ1_Y(y1), .REQ1_DATA(d1), .REQ1_READY(s_r1),
    .WRITE_EN(s_we), .WRITE_ADDR(s_addr), .WRITE_DATA(s_data),
    .BUSY(s_busy), .CLEAR_DONE(s_done), .DROP(s_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_write(input string tag, input logic we, input logic [18:0] addr,
                           input logic [23:0] data);
    chk({tag, "_we"}, 32'(m_we), 32'(we));
    chk({tag, "_addr"}, 32'(m_addr), 32'(addr));
    chk({tag, "_data"}, 32'(m_data), 32'(data));
  endtask

  initial begin
    rst = 1'b1; clr_m = 1'b0; clr_s = 1'b0;
    v0 = 1'b0; x0 = '0; y0 = '0; d0 = '0;
    v1 = 1'b0; x1 = '0; y1 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_write("reset", 1'b0, 19'd0, 24'd0);
    chk("reset_busy", 32'(m_busy), 32'd0);
    chk("reset_done", 32'(m_done), 32'd0);
    chk("reset_drop", 32'(m_drop), 32'd0);

    // Single pixel (3,2)
    next_cycle();
    rst = 1'b0;
    v0 = 1'b1; x0 = 10'd3; y0 = 10'd2; d0 = 24'h000001;
    @(negedge clk);
    chk("single_r0", 32'(m_r0), 32'd1);
    chk("single_r1", 32'(m_r1), 32'd0);
    next_cycle();
    v0 = 1'b0;
    @(negedge clk);
    chk_write("single", 1'b1, 19'd1283, 24'h000001);

    // REQ1 alone so that REQ1 is last served, then a 4-cycle tie
    next_cycle();
    v1 = 1'b1; x1 = 10'd5; y1 = 10'd0; d1 = 24'h0000aa;
    @(negedge clk);
    chk("solo1_r1", 32'(m_r1), 32'd1);
    chk("solo1_r0", 32'(m_r0), 32'd0);
    next_cycle();
    v1 = 1'b0;
    @(negedge clk);
    chk_write("solo1", 1'b1, 19'd5, 24'h0000aa);

    next_cycle();
    v0 = 1'b1; x0 = 10'd10; y0 = 10'd1; d0 = 24'h000100;
    v1 = 1'b1; x1 = 10'd20; y1 = 10'd1; d1 = 24'h000200;
    @(negedge clk);
    chk("rr0_r0", 32'(m_r0), 32'd1);
    chk("rr0_r1", 32'(m_r1), 32'd0);
    next_cycle();
    x0 = 10'd11; d0 = 24'h000101;
    @(negedge clk);
    chk("rr1_r0", 32'(m_r0), 32'd0);
    chk("rr1_r1", 32'(m_r1), 32'd1);
    chk_write("rr1", 1'b1, 19'd650, 24'h000100);
    next_cycle();
    x1 = 10'd21; d1 = 24'h000201;
    @(negedge clk);
    chk("rr2_r0", 32'(m_r0), 32'd1);
    chk("rr2_r1", 32'(m_r1), 32'd0);
    chk_write("rr2", 1'b1, 19'd660, 24'h000200);
    next_cycle();
    @(negedge clk);
    chk("rr3_r0", 32'(m_r0), 32'd0);
    chk("rr3_r1", 32'(m_r1), 32'd1);
    chk_write("rr3", 1'b1, 19'd651, 24'h000101);
    next_cycle();
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    chk_write("rr4", 1'b1, 19'd661, 24'h000201);

    // Corner pixel then out-of-range pixel
    next_cycle();
    v0 = 1'b1; x0 = 10'd639; y0 = 10'd479; d0 = 24'hffffff;
    @(negedge clk);
    chk("corner_r0", 32'(m_r0), 32'd1);
    next_cycle();
    x0 = 10'd640; y0 = 10'd0; d0 = 24'h000123;
    @(negedge clk);
    chk("oor_r0", 32'(m_r0), 32'd1);
    chk_write("corner", 1'b1, 19'd307199, 24'hffffff);
    chk("corner_drop", 32'(m_drop), 32'd0);
    next_cycle();
    v0 = 1'b0;
    @(negedge clk);
    chk_write("oor", 1'b0, 19'd307199, 24'hffffff);
    chk("oor_drop", 32'(m_drop), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("oor_drop_end", 32'(m_drop), 32'd0);

    // Main instance: clear with a pending request, reset at address 1000
    next_cycle();
    clr_m = 1'b1;
    v0 = 1'b1; x0 = 10'd1; y0 = 10'd1; d0 = 24'h000055;
    @(negedge clk);
    chk("mclr_r0", 32'(m_r0), 32'd0);
    next_cycle();
    clr_m = 1'b0;
    v1 = 1'b1; x1 = 10'd2; y1 = 10'd2; d1 = 24'h000066;
    @(negedge clk);
    chk("mclr_busy", 32'(m_busy), 32'd1);
    chk_write("mclr_a0", 1'b1, 19'd0, 24'd0);
    sweep_errs = 0;
    for (int a = 1; a <= 1000; a++) begin
      next_cycle();
      @(negedge clk);
      if (m_we !== 1'b1 || m_addr !== 19'(a) || m_data !== 24'd0 || m_busy !== 1'b1 ||
          m_r0 !== 1'b0 || m_r1 !== 1'b0 || m_done !== 1'b0)
        sweep_errs++;
    end
    chk("mclr_sweep_errs", 32'(sweep_errs), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk_write("mrst", 1'b0, 19'd0, 24'd0);
    chk("mrst_busy", 32'(m_busy), 32'd0);
    chk("mrst_r0", 32'(m_r0), 32'd0);
    chk("mrst_r1", 32'(m_r1), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mpost_busy", 32'(m_busy), 32'd0);
    chk("mpost_r0", 32'(m_r0), 32'd1);
    chk("mpost_r1", 32'(m_r1), 32'd0);
    chk("mpost_we", 32'(m_we), 32'd0);
    next_cycle();
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    chk_write("mpost", 1'b1, 19'd641, 24'h000055);

    // Small instance: full sweep of 192 addresses, second request mid-sweep
    next_cycle();
    clr_s = 1'b1;
    v1 = 1'b1; x1 = 10'd7; y1 = 10'd0; d1 = 24'h000777;
    @(negedge clk);
    chk("sclr_r1", 32'(s_r1), 32'd0);
    next_cycle();
    clr_s = 1'b0;
    @(negedge clk);
    chk("sclr_busy", 32'(s_busy), 32'd1);
    chk("sclr_we", 32'(s_we), 32'd1);
    chk("sclr_addr0", 32'(s_addr), 32'd0);
    chk("sclr_data0", 32'(s_data), 32'd0);
    sweep_errs = 0;
    for (int a = 1; a <= 191; a++) begin
      next_cycle();
      clr_s = (a == 50);
      @(negedge clk);
      if (s_we !== 1'b1 || s_addr !== 8'(a) || s_data !== 24'd0 || s_busy !== 1'b1 ||
          s_r1 !== 1'b0 || s_done !== (a == 191))
        sweep_errs++;
    end
    chk("sclr_sweep_errs", 32'(sweep_errs), 32'd0);
    chk("sclr_done_last", 32'(s_done), 32'd1);
    chk("sclr_addr_last", 32'(s_addr), 32'd191);
    next_cycle();
    clr_s = 1'b0;
    @(negedge clk);
    chk("sclr_end_busy", 32'(s_busy), 32'd0);
    chk("sclr_end_done", 32'(s_done), 32'd0);
    chk("sclr_end_we", 32'(s_we), 32'd0);
    chk("sclr_end_r1", 32'(s_r1), 32'd1);
    next_cycle();
    v1 = 1'b0;
    @(negedge clk);
    chk("sclr_px_we", 32'(s_we), 32'd1);
    chk("sclr_px_addr", 32'(s_addr), 32'd7);
    chk("sclr_px_data", 32'(s_data), 32'h000777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Single-clock write-side controller for the overlay frame buffer. It shares the buffer's write port between two pixel requesters with a valid/ready handshake and round-robin arbitration. It also runs a full-screen clear sweep on command. Requesters present (x, y, data); the block converts coordinates to the linear address y*VGA_WIDTH + x and drives the WRITE_ADDR / WRITE_DATA / WRITE_EN bus of the frame buffer write clock domain.

## Interface
- VGA_WIDTH, 640, visible pixels per line; x range 0..VGA_WIDTH-1
- VGA_HEIGHT, 480, visible lines; y range 0..VGA_HEIGHT-1
- ADDR_W, 19, write address width; VGA_WIDTH*VGA_HEIGHT <= 2^ADDR_W

Ports:
- CLK  in  1  write clock; same clock as frame buffer WRITE_CLK
- RESET  in  1  asynchronous, active-high reset
- CLEAR_REQ  in  1  one-cycle request to clear the whole buffer
- REQ0_VALID  in  1  requester 0 has a pixel
- REQ0_X  in  10  requester 0 x coordinate
- REQ0_Y  in  10  requester 0 y coordinate
- REQ0_DATA  in  24  requester 0 pixel data
- REQ0_READY  out  1  requester 0 accepted this cycle (VALID & READY)
- REQ1_VALID, REQ1_X, REQ1_Y, REQ1_DATA, REQ1_READY: same as requester 0
- WRITE_EN  out  1  write strobe to frame buffer
- WRITE_ADDR  out  ADDR_W  linear write address
- WRITE_DATA  out  24  write data
- BUSY  out  1  high while clear sweep is in progress
- CLEAR_DONE  out  1  one-cycle pulse on the last clear write
- DROP  out  1  one-cycle pulse when an accepted pixel is out of range

## Operation
- Two states: SERVE and CLEAR. Reset enters SERVE.
- SERVE, arbitration:
  - REQk_READY is combinational; at most one is high per cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not served last is granted.
  - The last-served pointer updates only on an accepted transfer. Reset value favours REQ0.
  - READY is high only when VALID is high and the requester is granted.
- Accept: the accepted x, y and data are registered.
  - Address = y*VGA_WIDTH + x, computed as an exact product truncated to ADDR_W bits.
  - If x >= VGA_WIDTH or y >= VGA_HEIGHT, the pixel is consumed (READY high) and no write occurs. DROP pulses in the cycle the write would have issued.
- CLEAR_REQ in SERVE:
  - Has priority over requests; both READY are 0 that cycle.
  - A write already registered from the previous cycle still issues.
  - Next state is CLEAR.
- CLEAR:
  - An address counter runs 0 .. VGA_WIDTH*VGA_HEIGHT-1, one write per cycle, WRITE_DATA = 0, WRITE_EN = 1.
  - Both READY stay 0. BUSY = 1. CLEAR_REQ is ignored.
  - On the final address, CLEAR_DONE pulses. Next state is SERVE and the counter returns to 0.
- RESET asserted at any time, including mid-sweep, aborts immediately. Clear progress and any registered pixel are discarded.

## Timing
- Reset values: WRITE_EN=0, WRITE_ADDR=0, WRITE_DATA=0, BUSY=0, CLEAR_DONE=0, DROP=0, both READY=0.
- WRITE_EN, WRITE_ADDR, WRITE_DATA, BUSY, CLEAR_DONE and DROP are all registered.
- Pixel latency:
  - Accept in cycle n gives WRITE_EN=1 with its address/data in cycle n+1.
  - Back-to-back accepts give one write per cycle, with no bubbles.
- WRITE_EN=0 in any cycle with no pending write; WRITE_ADDR/WRITE_DATA hold their last values.
- Clear latency:
  - CLEAR_REQ sampled high in cycle n (state SERVE) gives BUSY=1 and a write to address 0 in cycle n+1.
  - Address A is written in cycle n+1+A.
  - The last write (A = W*H-1) is in cycle n+W*H, with CLEAR_DONE=1 in that same cycle.
  - BUSY=0 and READY may assert again from cycle n+W*H+1.
- A pixel accepted in cycle n-1 writes in cycle n. The clear sweep never overlaps it.
- Simultaneous CLEAR_REQ and VALID in SERVE: neither requester is accepted. Requesters must hold VALID until READY.

## Test plan
- Single pixel: reset released, REQ0 (x=3, y=2, data=0x000001) -> REQ0_READY same cycle, next cycle WRITE_EN=1, WRITE_ADDR=1283, WRITE_DATA=0x000001.
- Round-robin: both valid for 4 cycles -> grants REQ0, REQ1, REQ0, REQ1; writes in that order on consecutive cycles, no gaps.
- Corner addresses: (639, 479) -> WRITE_ADDR=307199. (640, 0) -> READY=1, DROP=1 next cycle, WRITE_EN=0.
- Clear: CLEAR_REQ with REQ1 valid -> REQ1_READY=0. Writes to addresses 0..307199 with data 0. CLEAR_DONE with address 307199. REQ1 accepted the cycle after that.
- Clear ignore: second CLEAR_REQ mid-sweep -> no restart; sweep length remains 307200 writes.
- Reset mid-sweep at address 1000 -> all outputs 0 asynchronously. After release, state SERVE, BUSY=0, REQ0 wins the first tie.
